// File: rtl/flb_pkg.sv
// Shared Flow Bus definitions: type encodings, non-posted marker bit, request payload struct.
package flb_pkg;

  localparam int FLB_NP_BIT = 3;
  localparam int FLB_TAG_W  = 8;

  typedef enum logic [3:0] {
    FLB_MWR   = 4'h0,
    FLB_MSG   = 4'h1,
    FLB_IOWR  = 4'h2,
    FLB_CFGWR = 4'h3,
    FLB_MRD   = 4'h8,
    FLB_IORD  = 4'h9,
    FLB_CFGRD = 4'hA
  } flb_type_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [3:0]  ftype;
    logic [31:0] data;
    logic [3:0]  data_en;
    logic [63:0] addr;
    logic        wren;
  } flb_req_t;

  function automatic logic is_np(input logic [3:0] ftype);
    return ftype[FLB_NP_BIT];
  endfunction

endpackage

// File: rtl/flb_tag_pool.sv
// Non-posted tag pool: busy vector, lowest-free allocation, free count and sticky misuse flag.
module flb_tag_pool
  import flb_pkg::*;
#(
  parameter int NUM_TAGS = 32,
  parameter int TAG_W    = FLB_TAG_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             srst,
  input  logic             alloc,
  input  logic             free_valid,
  input  logic [TAG_W-1:0] free_tag,
  output logic             any_free,
  output logic [TAG_W-1:0] alloc_tag,
  output logic [TAG_W:0]   tags_free,
  output logic             tag_err
);

  logic [NUM_TAGS-1:0] busy_reg, busy_next;
  logic [NUM_TAGS-1:0] free_mask, alloc_mask;
  logic [TAG_W:0]      busy_cnt;
  logic                err_reg;

  // Out-of-range tags match no mask bit, so they fall into the error path too.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAGS; gi++) begin : g_tag
      assign free_mask[gi]  = free_valid && busy_reg[gi] && (free_tag == TAG_W'(gi));
      assign alloc_mask[gi] = alloc && any_free && (alloc_tag == TAG_W'(gi));
    end
  endgenerate

  always_comb begin
    alloc_tag = '0;
    any_free  = 1'b0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_reg[i]) begin
        alloc_tag = TAG_W'(i);
        any_free  = 1'b1;
      end
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      busy_cnt = busy_cnt + {{TAG_W{1'b0}}, busy_reg[i]};
    end
  end

  assign busy_next = (busy_reg & ~free_mask) | alloc_mask;
  assign tags_free = (TAG_W + 1)'(NUM_TAGS) - busy_cnt;
  assign tag_err   = err_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_reg <= '0;
      err_reg  <= 1'b0;
    end else if (srst) begin
      busy_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      if (free_valid && !(|free_mask)) err_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/flb_rq_arbiter.sv
// Round-robin arbiter for the FLB request port with non-posted tag ownership.
// Define FLB_ARB_PRIO0_EN to give requester 0 strict priority over the round-robin group.
module flb_rq_arbiter
  import flb_pkg::*;
#(
  parameter int  NUM_REQ  = 4,
  parameter int  NUM_TAGS = 32,
  parameter int  TAG_W    = FLB_TAG_W,
  localparam int SRC_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  srst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*4-1:0]  req_type,
  input  logic [NUM_REQ*32-1:0] req_data,
  input  logic [NUM_REQ*4-1:0]  req_data_en,
  input  logic [NUM_REQ*64-1:0] req_addr,
  input  logic [NUM_REQ-1:0]    req_wren,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  flb_request,
  output logic [3:0]            flb_type,
  output logic [31:0]           flb_data,
  output logic [3:0]            flb_data_en,
  output logic [63:0]           flb_addr,
  output logic                  flb_wren,
  input  logic                  flb_ready,
  output logic [TAG_W-1:0]      flb_tag,
  output logic [SRC_W-1:0]      flb_src,
  input  logic                  cpl_valid,
  input  logic [TAG_W-1:0]      cpl_tag,
  input  logic                  cpl_last,
  output logic [TAG_W:0]        tags_free,
  output logic                  tag_err
);

  arb_state_e        state_reg, state_next;
  logic [SRC_W-1:0]  rr_reg, rr_next;
  logic [SRC_W-1:0]  winner, win_hi, win_lo;
  logic              found_hi, found_lo, rr_upd, grant;
  logic [NUM_REQ-1:0] eligible;
  flb_req_t          sel, out_reg;
  logic [TAG_W-1:0]  tag_reg, alloc_tag;
  logic [SRC_W-1:0]  src_reg;
  logic              any_free, alloc;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign eligible[gi]  = req_valid[gi] && (!req_type[gi*4 + FLB_NP_BIT] || any_free);
      assign req_ready[gi] = grant && (winner == SRC_W'(gi));
    end
  endgenerate

  // Two scans: first eligible at/after rr_reg, else first eligible overall (the wrap).
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i] && (SRC_W'(i) >= rr_reg)) begin
        found_hi = 1'b1;
        win_hi   = SRC_W'(i);
      end
      if (eligible[i]) begin
        found_lo = 1'b1;
        win_lo   = SRC_W'(i);
      end
    end
    winner = found_hi ? win_hi : win_lo;
    rr_upd = found_lo;
`ifdef FLB_ARB_PRIO0_EN
    if (eligible[0]) begin
      winner = '0;
      rr_upd = 1'b0;
    end
`endif
  end

  assign rr_next = (winner == SRC_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == SRC_W'(i)) begin
        sel.ftype   = req_type[i*4 +: 4];
        sel.data    = req_data[i*32 +: 32];
        sel.data_en = req_data_en[i*4 +: 4];
        sel.addr    = req_addr[i*64 +: 64];
        sel.wren    = req_wren[i];
      end
    end
  end

  // req_ready is combinational, so it is gated off while either reset is active.
  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (found_lo && rstn && !srst) begin
          grant      = 1'b1;
          state_next = ARB_HOLD;
        end
      end
      ARB_HOLD: begin
        if (flb_ready) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= ARB_IDLE;
    else if (srst) state_reg <= ARB_IDLE;
    else state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_reg  <= '0;
      out_reg <= '0;
      tag_reg <= '0;
      src_reg <= '0;
    end else if (srst) begin
      rr_reg  <= '0;
      out_reg <= '0;
      tag_reg <= '0;
      src_reg <= '0;
    end else if (grant) begin
      out_reg <= sel;
      tag_reg <= is_np(sel.ftype) ? alloc_tag : '0;
      src_reg <= winner;
      if (rr_upd) rr_reg <= rr_next;
    end
  end

  assign alloc = grant && is_np(sel.ftype);

  flb_tag_pool #(
    .NUM_TAGS (NUM_TAGS),
    .TAG_W    (TAG_W)
  ) u_tag_pool (
    .clk        (clk),
    .rstn       (rstn),
    .srst       (srst),
    .alloc      (alloc),
    .free_valid (cpl_valid && cpl_last),
    .free_tag   (cpl_tag),
    .any_free   (any_free),
    .alloc_tag  (alloc_tag),
    .tags_free  (tags_free),
    .tag_err    (tag_err)
  );

  assign flb_request = (state_reg == ARB_HOLD);
  assign flb_type    = out_reg.ftype;
  assign flb_data    = out_reg.data;
  assign flb_data_en = out_reg.data_en;
  assign flb_addr    = out_reg.addr;
  assign flb_wren    = out_reg.wren;
  assign flb_tag     = tag_reg;
  assign flb_src     = src_reg;

endmodule

// File: tb/tb_flb_rq_arbiter.sv
// Randomized scoreboard bench for flb_rq_arbiter with a small tag pool to force read stalls.
module tb_flb_rq_arbiter;

  localparam int NR = 4;
  localparam int NT = 4;
  localparam int TW = 8;
  localparam int SW = 2;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic srst = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid, req_wren, req_ready;
  logic [NR*4-1:0]  req_type, req_data_en;
  logic [NR*32-1:0] req_data;
  logic [NR*64-1:0] req_addr;
  logic             flb_request, flb_wren, flb_ready, cpl_valid, cpl_last, tag_err;
  logic [3:0]       flb_type, flb_data_en;
  logic [31:0]      flb_data;
  logic [63:0]      flb_addr;
  logic [TW-1:0]    flb_tag, cpl_tag;
  logic [SW-1:0]    flb_src;
  logic [TW:0]      tags_free;

  flb_rq_arbiter #(.NUM_REQ(NR), .NUM_TAGS(NT), .TAG_W(TW)) dut (
    .clk(clk), .rstn(rstn), .srst(srst),
    .req_valid(req_valid), .req_type(req_type), .req_data(req_data),
    .req_data_en(req_data_en), .req_addr(req_addr), .req_wren(req_wren),
    .req_ready(req_ready), .flb_request(flb_request), .flb_type(flb_type),
    .flb_data(flb_data), .flb_data_en(flb_data_en), .flb_addr(flb_addr),
    .flb_wren(flb_wren), .flb_ready(flb_ready), .flb_tag(flb_tag), .flb_src(flb_src),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_last(cpl_last),
    .tags_free(tags_free), .tag_err(tag_err)
  );

  typedef struct {
    int          src;
    logic [3:0]  ty;
    logic [31:0] d;
    logic [3:0]  be;
    logic [63:0] a;
    logic        w;
    int          tag;
  } txn_t;

  txn_t exp_q[$];
  txn_t req_t[NR];
  bit   pend[NR];
  bit   m_busy[NT];
  int   m_rr, nfree, win, n_xfer;
  bit   m_hold, m_err, did_srst, post_srst;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic bit elig(int i);
    return pend[i] && (!req_t[i].ty[3] || nfree > 0);
  endfunction

  // Monitor: every accepted FLB beat must match the oldest predicted grant.
  initial begin
    logic [114:0] act, exp;
    txn_t t;
    wait (rstn === 1'b1);
    forever begin
      @(negedge clk);
      #2;
      if (flb_request && flb_ready && !srst) begin
        vectors++;
        act = {flb_src, flb_type, flb_data, flb_data_en, flb_addr, flb_wren, flb_tag};
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL xfer_unexpected: got %0h expected no transfer", act);
        end else begin
          t = exp_q.pop_front();
          exp = {SW'(t.src), t.ty, t.d, t.be, t.a, t.w, TW'(t.tag)};
          n_xfer++;
          if (act !== exp) begin
            miscompares++;
            $display("FAIL xfer: got %0h expected %0h", act, exp);
          end
        end
      end
    end
  end

  initial begin
    int bl[$];
    int ft;
    bit do_free;
    logic [NR-1:0] exp_rdy;
    txn_t t;

    req_valid = '1; req_type = '0; req_data = '0; req_data_en = '0;
    req_addr = '0; req_wren = '0; flb_ready = 1'b0;
    cpl_valid = 1'b0; cpl_tag = '0; cpl_last = 1'b0;
    m_rr = 0; m_hold = 0; m_err = 0; did_srst = 0; post_srst = 0; n_xfer = 0;
    for (int i = 0; i < NT; i++) m_busy[i] = 0;
    for (int i = 0; i < NR; i++) pend[i] = 0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_flb_request", flb_request, 0);
    chk("rst_tags_free", tags_free, NT);
    chk("rst_tag_err", tag_err, 0);
    chk("rst_flb_addr", flb_addr, 0);
    req_valid = '0;
    rstn = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      nfree = 0;
      for (int k = 0; k < NT; k++) if (!m_busy[k]) nfree++;

      srst = (cyc >= NCYC / 2) && !did_srst && m_hold && (nfree < NT);
      flb_ready = srst ? 1'b0 :
                  ((cyc % 80) < 15) ? 1'b0 : ($urandom_range(0, 9) < 7);

      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]     = 1;
          req_t[i].src = i;
          req_t[i].ty = 4'($urandom_range(0, 15));
          req_t[i].d  = $urandom;
          req_t[i].be = 4'($urandom_range(0, 15));
          req_t[i].a  = {$urandom, $urandom};
          req_t[i].w  = 1'($urandom_range(0, 1));
        end
        req_valid[i]          = pend[i];
        req_type[i*4 +: 4]    = req_t[i].ty;
        req_data[i*32 +: 32]  = req_t[i].d;
        req_data_en[i*4 +: 4] = req_t[i].be;
        req_addr[i*64 +: 64]  = req_t[i].a;
        req_wren[i]           = req_t[i].w;
      end

      cpl_valid = 1'b0; cpl_last = 1'b0; cpl_tag = '0;
      if ($urandom_range(0, 5) == 0) begin
        if (cyc > NCYC * 5 / 6 && $urandom_range(0, 2) == 0) begin
          cpl_valid = 1'b1; cpl_last = 1'b1;
          cpl_tag = TW'($urandom_range(0, NT + 3));
        end else begin
          bl.delete();
          for (int k = 0; k < NT; k++) if (m_busy[k]) bl.push_back(k);
          if (bl.size() > 0) begin
            cpl_valid = 1'b1;
            cpl_last  = ($urandom_range(0, 3) != 0);
            cpl_tag   = TW'(bl[$urandom_range(0, bl.size() - 1)]);
          end
        end
      end

      win = -1;
      if (!m_hold && !srst) begin
`ifdef FLB_ARB_PRIO0_EN
        if (elig(0)) win = 0;
`endif
        for (int k = 0; k < NR && win < 0; k++)
          if (elig((m_rr + k) % NR)) win = (m_rr + k) % NR;
      end

      #1;
      exp_rdy = (win >= 0) ? (NR'(1) << win) : '0;
      chk("req_ready", req_ready, exp_rdy);
      chk("flb_request", flb_request, m_hold);
      chk("tags_free", tags_free, nfree);
      chk("tag_err", tag_err, m_err);
      if (post_srst) begin
        chk("srst_flb_addr", flb_addr, 0);
        post_srst = 0;
      end

      if (srst) begin
        for (int k = 0; k < NT; k++) m_busy[k] = 0;
        m_hold = 0; m_rr = 0; m_err = 0;
        exp_q.delete();
        did_srst = 1; post_srst = 1;
      end else begin
        do_free = 0; ft = 0;
        if (cpl_valid && cpl_last) begin
          if (int'(cpl_tag) < NT && m_busy[int'(cpl_tag)]) begin
            do_free = 1; ft = int'(cpl_tag);
          end else m_err = 1;
        end
        if (m_hold && flb_ready) m_hold = 0;
        else if (win >= 0) begin
          t = req_t[win];
          t.tag = 0;
          if (t.ty[3]) begin
            for (int k = NT - 1; k >= 0; k--) if (!m_busy[k]) t.tag = k;
            m_busy[t.tag] = 1;
          end
          exp_q.push_back(t);
          pend[win] = 0;
          m_hold = 1;
`ifdef FLB_ARB_PRIO0_EN
          if (win != 0) m_rr = (win + 1) % NR;
`else
          m_rr = (win + 1) % NR;
`endif
        end
        if (do_free) m_busy[ft] = 0;
      end
    end

    @(negedge clk);
    srst = 1'b0;
    #3;
    chk("queue_drain", exp_q.size(), m_hold ? 1 : 0);
    chk("xfer_count_min", n_xfer >= 100, 1);
    chk("srst_exercised", did_srst, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
